dmem_lsu: RTL and testbench

Parametrised, byte-addressable data memory with a built-in load/store alignment unit. It replaces the fixed 256×32 word memory with combinational read. It adds byte/half/word (optionally dword) accesses, per-lane write enables, sign/zero extension, misalignment detection, a request/grant handshake with registered one-cycle read latency, and a post-reset zero-fill sequence. It sits between the core's memory stage and the data storage.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 49 ++++
 rtl/dmem_lsu.sv | 167 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and the lane-mask helper for the dmem_lsu data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int MAX_LANES = 8;

    // Byte lanes touched by an access of the given size starting at offset.
    function automatic logic [MAX_LANES-1:0] lane_mask(input size_e size, input logic [2:0] offset);
        logic [MAX_LANES-1:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte-lane write enables and a registered read port.
// Defining DMEM_PARITY_EN keeps one even-parity bit per byte lane alongside the data.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [DATA_W/8-1:0]      i_be,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
`ifdef DMEM_PARITY_EN
    ,
    output logic [DATA_W/8-1:0]      o_rpar
`endif
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the storage has no reset; clearing it takes DEPTH cycles and is the LSU's zero-fill job.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_we && i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
        if (i_re) r_rdata <= r_mem[i_idx];
    end

    assign o_rdata = r_rdata;

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] r_rpar;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_we && i_be[b]) r_par[i_idx][b] <= ^i_wdata[8*b +: 8];
        end
        if (i_re) r_rpar <= r_par[i_idx];
    end

    assign o_rpar = r_rpar;
`endif

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with load/store alignment, extension and post-reset zero-fill.
// Optional macro DMEM_PARITY_EN enables per-lane parity storage and checking on perr_o.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    localparam int ADDR_W = $clog2(DEPTH) + $clog2(DATA_W/8)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              perr_o,
    output logic              busy_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    state_e             r_state, w_next_state;
    logic [CNT_W-1:0]   r_cnt;

    size_e              w_size;
    logic [OFF_W-1:0]   w_off;
    logic               w_err, w_init, w_acc;
    logic [NB-1:0]      w_mask;
    logic [DATA_W-1:0]  w_wdata_sh;

    logic               w_arr_we, w_arr_re;
    logic [NB-1:0]      w_arr_be;
    logic [IDX_W-1:0]   w_arr_idx;
    logic [DATA_W-1:0]  w_arr_wdata, w_arr_rdata;

    logic               r_rvalid, r_err, r_zero, r_uns;
    size_e              r_size;
    logic [OFF_W-1:0]   r_off;
    logic [DATA_W-1:0]  w_rshift, w_low, w_msb, w_ext;
    logic               w_sign;

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (!rst_ni) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT:  if (r_cnt == CNT_W'(DEPTH - 1)) w_next_state = ST_READY;
            ST_READY: w_next_state = ST_READY;
            default:  w_next_state = ST_INIT;
        endcase
    end

    assign w_size = size_e'(size_i);
    assign w_off  = addr_i[OFF_W-1:0];
    assign w_init = (r_state == ST_INIT);
    assign w_acc  = (r_state == ST_READY) & req_i & rst_ni;

    always_comb begin
        // NOTE: default assigned first so every path drives w_err and no latch is inferred.
        w_err = 1'b0;
        case (w_size)
            SZ_H:    w_err = addr_i[0];
            SZ_W:    w_err = |addr_i[1:0];
            SZ_D:    w_err = (DATA_W == 32) ? 1'b1 : |addr_i[2:0];
            default: w_err = 1'b0;
        endcase
    end

    assign w_mask     = NB'(lane_mask(w_size, 3'(w_off)));
    assign w_wdata_sh = wdata_i << {w_off, 3'b000};

    // Zero-fill owns the array port until the last word is cleared.
    assign w_arr_we    = w_init | (w_acc & we_i & ~w_err);
    assign w_arr_re    = w_acc & ~we_i & ~w_err;
    assign w_arr_be    = w_init ? '1 : w_mask;
    assign w_arr_idx   = w_init ? r_cnt[IDX_W-1:0] : addr_i[ADDR_W-1:OFF_W];
    assign w_arr_wdata = w_init ? '0 : w_wdata_sh;

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] w_arr_rpar, r_mask, w_lane_par;
`endif

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_be    (w_arr_be),
        .i_idx   (w_arr_idx),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
`ifdef DMEM_PARITY_EN
        ,
        .o_rpar  (w_arr_rpar)
`endif
    );

    // Access attributes only move on an accepted request, so rdata_o holds between responses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_zero   <= 1'b1;
            r_uns    <= 1'b0;
            r_size   <= SZ_B;
            r_off    <= '0;
        end else begin
            r_rvalid <= w_acc;
            if (w_acc) begin
                r_err  <= w_err;
                r_zero <= we_i | w_err;
                r_uns  <= unsigned_i;
                r_size <= w_size;
                r_off  <= w_off;
            end
        end
    end

    assign w_rshift = w_arr_rdata >> {r_off, 3'b000};
    assign w_low    = ~({DATA_W{1'b1}} << (32'd8 << r_size));
    assign w_msb    = w_low ^ (w_low >> 1);
    assign w_sign   = ~r_uns & |(w_rshift & w_msb);
    assign w_ext    = (w_rshift & w_low) | ({DATA_W{w_sign}} & ~w_low);

    assign rdata_o  = r_zero ? '0 : w_ext;
    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign gnt_o    = w_acc;
    assign busy_o   = w_init;

`ifdef DMEM_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)    r_mask <= '0;
        else if (w_acc) r_mask <= w_mask;
    end

    always_comb begin
        w_lane_par = '0;
        for (int b = 0; b < NB; b++) w_lane_par[b] = ^w_arr_rdata[8*b +: 8];
    end

    assign perr_o = r_rvalid & ~r_zero & |((w_lane_par ^ w_arr_rpar) & r_mask);
`else
    assign perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed steps plus random traffic against a byte-array model.
module tb_dmem_lsu;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 10;
    localparam int NBYTES = DEPTH * (DATA_W / 8);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_i = 1'b0;
    logic              we_i = 1'b0;
    logic [1:0]        size_i = 2'b00;
    logic              unsigned_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [DATA_W-1:0] wdata_i = '0;
    logic              gnt_o, rvalid_o, err_o, perr_o, busy_o;
    logic [DATA_W-1:0] rdata_o;

    always #5 clk_i = ~clk_i;

    dmem_lsu #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .perr_o     (perr_o),
        .busy_o     (busy_o)
    );

    logic [7:0]  model [NBYTES];
    logic [31:0] last_rdata = '0;
    logic        exp_perr = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit misaligned(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return a[1:0] != 2'b00;
            default: return 1'b1;  // dword does not exist on a 32-bit memory
        endcase
    endfunction

    // Reference behaviour: memory is a flat byte array, little-endian lanes.
    task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                                input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                                output logic [31:0] exp_rd, output logic exp_err);
        int          n;
        logic [31:0] v;
        logic [63:0] keep;
        exp_rd  = '0;
        exp_err = misaligned(sz, a);
        if (exp_err) return;
        n = 1 << sz;
        if (w) begin
            for (int i = 0; i < n; i++) model[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = model[int'(a) + i];
            keep = (64'd1 << (8 * n)) - 64'd1;
            if (!u && v[8*n-1]) v = v | ~keep[31:0];
            exp_rd = v;
        end
    endtask

    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [ADDR_W-1:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] er;
        logic        ee;
        @(negedge clk_i);
        req_i = 1'b1; we_i = w; size_i = sz; unsigned_i = u; addr_i = a; wdata_i = wd;
        #1 check({tag, ".gnt"}, 32'(gnt_o), 32'd1);
        model_access(w, sz, u, a, wd, er, ee);
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        check({tag, ".rvalid"}, 32'(rvalid_o), 32'd1);
        check({tag, ".rdata"}, rdata_o, er);
        check({tag, ".err"}, 32'(err_o), 32'(ee));
        check({tag, ".perr"}, 32'(perr_o), 32'(exp_perr));
        last_rdata = er;
    endtask

    task automatic idle(input string tag);
        @(negedge clk_i);
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        check({tag, ".rvalid"}, 32'(rvalid_o), 32'd0);
        check({tag, ".hold"}, rdata_o, last_rdata);
    endtask

    // Reset with a live load request, then count the zero-fill and answer that load.
    task automatic do_reset(input int hold, input string tag);
        int cycles;
        bit saw_rvalid;
        @(negedge clk_i);
        rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; size_i = 2'b10;
        unsigned_i = 1'b0; addr_i = 10'h3FC; wdata_i = '0;
        repeat (hold) @(posedge clk_i);
        #1;
        check({tag, ".rst_rvalid"}, 32'(rvalid_o), 32'd0);
        check({tag, ".rst_busy"}, 32'(busy_o), 32'd1);
        check({tag, ".rst_gnt"}, 32'(gnt_o), 32'd0);
        check({tag, ".rst_rdata"}, rdata_o, 32'd0);
        check({tag, ".rst_err"}, 32'(err_o), 32'd0);
        check({tag, ".rst_perr"}, 32'(perr_o), 32'd0);
        for (int i = 0; i < NBYTES; i++) model[i] = 8'h00;
        last_rdata = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycles = 0;
        saw_rvalid = 1'b0;
        while (busy_o === 1'b1 && gnt_o === 1'b0 && cycles < 1000) begin
            cycles++;
            if (rvalid_o !== 1'b0) saw_rvalid = 1'b1;
            @(negedge clk_i);
        end
        check({tag, ".fill_cycles"}, 32'(cycles), 32'(DEPTH));
        check({tag, ".fill_rvalid"}, 32'(saw_rvalid), 32'd0);
        check({tag, ".ready_gnt"}, 32'(gnt_o), 32'd1);
        check({tag, ".ready_busy"}, 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        check({tag, ".top_rvalid"}, 32'(rvalid_o), 32'd1);
        check({tag, ".top_rdata"}, rdata_o, 32'd0);
        check({tag, ".top_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(2, "zf");

        access(1'b1, 2'b10, 1'b0, 10'h010, 32'h1122_3344, "lane.stw");
        access(1'b1, 2'b00, 1'b0, 10'h012, 32'h0000_00AB, "lane.stb");
        access(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, "lane.ldw");
        idle("lane.idle");

        access(1'b1, 2'b01, 1'b0, 10'h020, 32'h0000_8001, "ext.sth");
        access(1'b0, 2'b01, 1'b0, 10'h020, 32'h0, "ext.ldh_s");
        access(1'b0, 2'b01, 1'b1, 10'h020, 32'h0, "ext.ldh_u");
        access(1'b0, 2'b00, 1'b0, 10'h021, 32'h0, "ext.ldb_s");
        access(1'b0, 2'b00, 1'b1, 10'h021, 32'h0, "ext.ldb_u");

        access(1'b1, 2'b10, 1'b0, 10'h031, 32'hDEAD_BEEF, "mis.stw");
        access(1'b0, 2'b10, 1'b0, 10'h030, 32'h0, "mis.ldw");
        access(1'b0, 2'b01, 1'b0, 10'h033, 32'h0, "mis.ldh");
        access(1'b0, 2'b11, 1'b0, 10'h000, 32'h0, "mis.size3");
        idle("mis.idle");

        access(1'b1, 2'b10, 1'b0, 10'h040, 32'hA5C3_0F96, "b2b.st");
        access(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, "b2b.ld");
        idle("b2b.idle");

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle("rnd.idle");
            end else begin
                access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       ADDR_W'(10'h080 + $urandom_range(0, 127)), $urandom(), "rnd");
            end
        end

`ifdef DMEM_PARITY_EN
        access(1'b1, 2'b10, 1'b0, 10'h050, 32'h0F0F_1234, "par.st");
        @(negedge clk_i);
        dut.u_array.r_par[20][0] = ~dut.u_array.r_par[20][0];
        exp_perr = 1'b1;
        access(1'b0, 2'b10, 1'b0, 10'h050, 32'h0, "par.ld");
        exp_perr = 1'b0;
        access(1'b0, 2'b00, 1'b0, 10'h051, 32'h0, "par.other_lane");
`endif

        access(1'b1, 2'b10, 1'b0, 10'h060, 32'hCAFE_F00D, "mid.st");
        do_reset(1, "mid");
        access(1'b0, 2'b10, 1'b0, 10'h060, 32'h0, "mid.ld");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
